// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Optional retired-instruction counter enabled by macro CTRL_INSTRET_EN.
module multicycle_ctrl #(
  parameter int              OP_W    = 6,
  parameter logic [OP_W-1:0] JR_FUNC = 6'b001000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] Instruction_class,
  input  logic [OP_W-1:0] func,
  input  logic            ZERO,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic [1:0]      MemtoReg,
  output logic            MemRead,
  output logic            ALU_SRC,
  output logic [3:0]      ALUop,
  output logic [1:0]      RegDst,
  output logic [1:0]      NPCop,
  output logic            RegWrite,
  output logic            EXTop,
  output logic            retire,
  output logic [31:0]     instret
);

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI  = 6'b001111;
  localparam logic [OP_W-1:0] OP_JAL  = 6'b000011;
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW,
    C_SW, C_BEQ, C_JR, C_JAL, C_BAD
  } cls_t;

  state_t          r_state;
  logic [OP_W-1:0] r_op;
  logic [OP_W-1:0] r_func;
  cls_t            w_cls;

  function automatic cls_t classify(
    input logic [OP_W-1:0] op,
    input logic [OP_W-1:0] fn
  );
    cls_t c;
    c = C_BAD;
    case (op)
      OP_R: begin
        if (fn == FN_ADDU)      c = C_ADDU;
        else if (fn == FN_SUBU) c = C_SUBU;
        else if (fn == JR_FUNC) c = C_JR;
        else                    c = C_BAD;
      end
      OP_ORI:  c = C_ORI;
      OP_LUI:  c = C_LUI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      OP_JAL:  c = C_JAL;
      default: c = C_BAD;
    endcase
    return c;
  endfunction

  // DECODE sees the live splitter fields; later states use the latched copy
  assign w_cls = (r_state == S_DECODE) ? classify(Instruction_class, func)
                                       : classify(r_op, r_func);

  // State sequencing and opcode/func latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
      r_func  <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_op   <= Instruction_class;
          r_func <= func;
          case (w_cls)
            C_JAL:   r_state <= S_WB;
            C_BAD:   r_state <= S_FETCH;
            default: r_state <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (w_cls)
            C_ADDU, C_SUBU, C_ORI, C_LUI: r_state <= S_WB;
            C_LW, C_SW:                   r_state <= S_MEM;
            default:                      r_state <= S_FETCH;
          endcase
        end
        S_MEM:   r_state <= (w_cls == C_LW) ? S_WB : S_FETCH;
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Control strobes; a reset cycle shows only the FETCH defaults
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 2'd0;
    MemRead  = 1'b0;
    ALU_SRC  = 1'b0;
    ALUop    = 4'd0;
    RegDst   = 2'd0;
    NPCop    = 2'd0;
    RegWrite = 1'b0;
    EXTop    = 1'b0;
    retire   = 1'b0;
    if (reset) begin
      IRWrite = 1'b1;
    end else begin
      case (r_state)
        S_FETCH: IRWrite = 1'b1;
        S_DECODE: begin
          if (w_cls == C_BAD) begin
            PCWrite = 1'b1;
            retire  = 1'b1;
          end
        end
        S_EXEC: begin
          case (w_cls)
            C_ADDU: ALUop = 4'd0;
            C_SUBU: ALUop = 4'd1;
            C_ORI: begin
              ALU_SRC = 1'b1;
              ALUop   = 4'd2;
            end
            C_LUI: begin
              ALU_SRC = 1'b1;
              ALUop   = 4'd3;
            end
            C_LW, C_SW: begin
              ALU_SRC = 1'b1;
              EXTop   = 1'b1;
            end
            C_BEQ: begin
              ALUop   = 4'd1;
              EXTop   = 1'b1;
              PCWrite = 1'b1;
              NPCop   = ZERO ? 2'd1 : 2'd0;
              retire  = 1'b1;
            end
            C_JR: begin
              PCWrite = 1'b1;
              NPCop   = 2'd3;
              retire  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (w_cls == C_SW) begin
            MemRead = 1'b1;
            PCWrite = 1'b1;
            retire  = 1'b1;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          retire   = 1'b1;
          case (w_cls)
            C_ADDU, C_SUBU: RegDst = 2'd1;
            C_LW:           MemtoReg = 2'd1;
            C_JAL: begin
              RegDst   = 2'd2;
              MemtoReg = 2'd2;
              NPCop    = 2'd2;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_INSTRET_EN
  logic [31:0] r_instret;

  // Count every retiring cycle, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset)       r_instret <= 32'd0;
    else if (retire) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl.
// Per-instruction cycle tables, randomized mix, mid-instruction reset.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Instruction_class;
  logic [5:0]  func;
  logic        ZERO;
  logic        PCWrite, IRWrite, MemRead, ALU_SRC;
  logic        RegWrite, EXTop, retire;
  logic [1:0]  MemtoReg, RegDst, NPCop;
  logic [3:0]  ALUop;
  logic [31:0] instret;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic [1:0] m2r;
    logic       mrd;
    logic       asrc;
    logic [3:0] aop;
    logic [1:0] rdst;
    logic [1:0] npc;
    logic       rw;
    logic       ext;
    logic       ret;
  } ctl_t;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3;
  localparam int K_LW = 4, K_SW = 5, K_BEQ = 6, K_JR = 7;
  localparam int K_JAL = 8, K_BAD = 9;

  ctl_t        obs;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned model_cnt = 0;

  assign obs = {PCWrite, IRWrite, MemtoReg, MemRead, ALU_SRC, ALUop,
                RegDst, NPCop, RegWrite, EXTop, retire};

  multicycle_ctrl dut (
    .clk(clk), .reset(reset),
    .Instruction_class(Instruction_class), .func(func), .ZERO(ZERO),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .MemRead(MemRead), .ALU_SRC(ALU_SRC), .ALUop(ALUop),
    .RegDst(RegDst), .NPCop(NPCop), .RegWrite(RegWrite),
    .EXTop(EXTop), .retire(retire), .instret(instret)
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    case (k)
      K_LW:                 return 5;
      K_BEQ, K_JR, K_JAL:   return 3;
      K_BAD:                return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic ctl_t wb(input ctl_t e);
    ctl_t r;
    r = e;
    r.rw  = 1'b1;
    r.pcw = 1'b1;
    r.ret = 1'b1;
    return r;
  endfunction

  // Expected bundle at cycle c of an instruction of kind k
  function automatic ctl_t exp_ctl(input int k, input int c, input logic z);
    ctl_t e;
    e = '0;
    if (c == 0) begin
      e.irw = 1'b1;
    end else if (k == K_BAD) begin
      if (c == 1) begin
        e.pcw = 1'b1;
        e.ret = 1'b1;
      end
    end else if (k == K_JAL) begin
      if (c == 2) begin
        e.rdst = 2'd2;
        e.m2r  = 2'd2;
        e.npc  = 2'd2;
        e = wb(e);
      end
    end else if (c == 2) begin
      case (k)
        K_SUBU: e.aop = 4'd1;
        K_ORI: begin e.asrc = 1'b1; e.aop = 4'd2; end
        K_LUI: begin e.asrc = 1'b1; e.aop = 4'd3; end
        K_LW, K_SW: begin e.asrc = 1'b1; e.ext = 1'b1; end
        K_BEQ: begin
          e.aop = 4'd1; e.ext = 1'b1; e.pcw = 1'b1; e.ret = 1'b1;
          e.npc = z ? 2'd1 : 2'd0;
        end
        K_JR: begin e.pcw = 1'b1; e.ret = 1'b1; e.npc = 2'd3; end
        default: ;
      endcase
    end else if (c == 3) begin
      case (k)
        K_ADDU, K_SUBU: begin e.rdst = 2'd1; e = wb(e); end
        K_ORI, K_LUI:   e = wb(e);
        K_SW: begin e.mrd = 1'b1; e.pcw = 1'b1; e.ret = 1'b1; end
        default: ;
      endcase
    end else if (c == 4 && k == K_LW) begin
      e.m2r = 2'd1;
      e = wb(e);
    end
    return e;
  endfunction

  function automatic logic [31:0] exp_inst();
`ifdef CTRL_INSTRET_EN
    return model_cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b001101, 6'b100011, 6'b101011,
                      6'b000100, 6'b001111, 6'b000011};
  endfunction

  task automatic pick(input int k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (k)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LUI:  op = 6'b001111;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_JAL:  op = 6'b000011;
      default: begin
        if ($urandom_range(1) == 0) begin
          op = 6'b000000;
          while (fn inside {6'b100001, 6'b100011, 6'b001000})
            fn = 6'($urandom);
        end else begin
          op = 6'($urandom);
          while (is_legal_op(op)) op = 6'($urandom);
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Run one instruction; cycles limits how many cycles are stepped
  task automatic run(input int k, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (c == 1) begin
        Instruction_class = op;
        func = fn;
      end else begin
        Instruction_class = 6'($urandom);
        func = 6'($urandom);
      end
      ZERO = (c == 2) ? z : 1'($urandom);
      @(negedge clk);
      chk($sformatf("k%0d_op%b_c%0d", k, op, c),
          32'(obs), 32'(exp_ctl(k, c, z)));
      @(posedge clk);
      #1;
    end
    if (cycles == lat_of(k)) begin
      model_cnt++;
      chk($sformatf("instret_k%0d", k), instret, exp_inst());
    end
  endtask

  initial begin
    logic [5:0] op, fn;
    ctl_t       fetch_only;
    int         k;
    fetch_only     = '0;
    fetch_only.irw = 1'b1;

    reset = 1'b1;
    Instruction_class = 6'b000000;
    func = 6'b100001;
    ZERO = 1'b0;
    @(negedge clk);
    chk("reset_ctl", 32'(obs), 32'(fetch_only));
    chk("reset_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(K_ADDU, 6'b000000, 6'b100001, 1'b0, 4);
    run(K_LW,   6'b100011, 6'b000000, 1'b0, 5);
    run(K_SW,   6'b101011, 6'b000000, 1'b0, 4);
    run(K_BEQ,  6'b000100, 6'b000000, 1'b1, 3);
    run(K_BEQ,  6'b000100, 6'b000000, 1'b0, 3);
    run(K_JAL,  6'b000011, 6'b000000, 1'b0, 3);
    run(K_JR,   6'b000000, 6'b001000, 1'b0, 3);
    run(K_BAD,  6'b111111, 6'b000000, 1'b0, 2);
    run(K_SUBU, 6'b000000, 6'b100011, 1'b0, 4);
    run(K_ORI,  6'b001101, 6'b000000, 1'b0, 4);
    run(K_LUI,  6'b001111, 6'b000000, 1'b0, 4);
    run(K_BAD,  6'b000000, 6'b000000, 1'b0, 2);

    // lw aborted by reset in its MEM cycle
    run(K_LW, 6'b100011, 6'b000000, 1'b0, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_mem_ctl", 32'(obs), 32'(fetch_only));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
    @(negedge clk);
    chk("after_reset_fetch", 32'(obs), 32'(fetch_only));
    chk("after_reset_instret", instret, exp_inst());
    @(posedge clk);
    #1;
    // instruction resumes from FETCH already taken above: finish it
    Instruction_class = 6'b000000;
    func = 6'b100001;
    ZERO = 1'b0;
    @(negedge clk);
    chk("after_reset_decode", 32'(obs), 32'(exp_ctl(K_ADDU, 1, 1'b0)));
    @(posedge clk);
    #1;
    Instruction_class = 6'($urandom);
    func = 6'($urandom);
    @(negedge clk);
    chk("after_reset_exec", 32'(obs), 32'(exp_ctl(K_ADDU, 2, 1'b0)));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_reset_wb", 32'(obs), 32'(exp_ctl(K_ADDU, 3, 1'b0)));
    @(posedge clk);
    #1;
    model_cnt++;
    chk("after_reset_instret1", instret, exp_inst());

    for (int n = 0; n < 60; n++) begin
      logic z;
      k = int'($urandom_range(9));
      pick(k, op, fn);
      z = 1'($urandom);
      run(k, op, fn, z, lat_of(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB so one ALU and one memory port are reused across cycles.
- Drives the same control bundle the single-cycle datapath consumes, plus PC and IR write strobes.
- Sits beside the datapath at top level. Takes opcode/func/ZERO back from the splitter and ALU.

Parameters:
- OP_W, 6, opcode and func field width.
- JR_FUNC, 6'b001000, func code that selects jr inside R-type.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset; all state cleared on the clk edge where reset=1
- Instruction_class  input  6  opcode from splitter, valid in DECODE
- func  input  6  func field from splitter, valid in DECODE
- ZERO  input  1  ALU equality flag, sampled in EXEC
- PCWrite  output  1  PC register load enable
- IRWrite  output  1  instruction register load enable
- MemtoReg  output  2  0=ALU, 1=Mem, 2=PC4
- MemRead  output  1  DM write strobe (datapath naming)
- ALU_SRC  output  1  0=read2, 1=ExtImm16
- ALUop  output  4  0=add, 1=sub, 2=or, 3=lui (imm<<16)
- RegDst  output  2  0=rt, 1=rd, 2=$31
- NPCop  output  2  0=PC+4, 1=branch, 2=jal, 3=jr
- RegWrite  output  1  GRF write enable
- EXTop  output  1  0=zero-ext, 1=sign-ext
- retire  output  1  one-cycle pulse in the last cycle of each instruction
- instret  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; 3-bit encoded register.
- Reset: state=FETCH, latched op/func=0. Combinational outputs then give IRWrite=1 and all other strobes 0.
- FETCH: IRWrite=1; next=DECODE.
- DECODE: latch Instruction_class/func into internal regs; classify.
  - jal: next=WB.
  - Unknown opcode, or R-type with func outside {100001, 100011, JR_FUNC}: no-op. PCWrite=1, NPCop=0, retire=1; next=FETCH.
  - All others: next=EXEC.
- EXEC:
  - addu/subu: ALU_SRC=0, ALUop=0/1; next=WB.
  - ori: ALU_SRC=1, EXTop=0, ALUop=2; next=WB.
  - lui: ALU_SRC=1, ALUop=3; next=WB.
  - lw/sw: ALU_SRC=1, EXTop=1, ALUop=0; next=MEM.
  - beq: ALUop=1, EXTop=1, PCWrite=1, NPCop=(ZERO?1:0), retire=1; next=FETCH.
  - jr: PCWrite=1, NPCop=3, retire=1; next=FETCH.
- MEM:
  - sw: MemRead=1, PCWrite=1, NPCop=0, retire=1; next=FETCH.
  - lw: next=WB.
- WB: RegWrite=1, PCWrite=1, retire=1; next=FETCH.
  - R-type: RegDst=1, MemtoReg=0.
  - ori/lui: RegDst=0, MemtoReg=0.
  - lw: RegDst=0, MemtoReg=1.
  - jal: RegDst=2, MemtoReg=2, NPCop=2.
  - NPCop=0 for every WB case except jal.
- Latency in cycles: R-type/ori/lui 4, lw 5, sw 4, beq 3, jr 3, jal 3, unknown 2.
- Invariants:
  - Exactly one PCWrite pulse per instruction, always coincident with retire.
  - RegWrite only in WB; MemRead only in MEM.
  - Any strobe not listed for a state is 0.
- Opcodes: R=000000, ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, jal=000011. R func: addu=100001, subu=100011.
- Reset mid-instruction: next edge returns to FETCH; no strobe asserts in the reset cycle beyond FETCH defaults. Aborted instruction neither retires nor counts.
- Illegal state encodings (5–7) go to FETCH.

Optional Feature:
- Macro CTRL_INSTRET_EN.
- Defined: instret is a 32-bit counter, reset to 0, +1 on every cycle with retire=1, wraps 0xFFFFFFFF→0.
- Undefined: instret tied to 32'h0, no counter flops.

Test Plan:
- Reset held 2 cycles then released, op=addu (000000/100001) → state FETCH, IRWrite=1, PCWrite=0. Then DECODE, EXEC (ALUop=0, ALU_SRC=0), WB (RegWrite=1, RegDst=1, PCWrite=1, retire=1); 4 cycles total.
- lw (100011) → 5 cycles; MEM has MemRead=0; WB has MemtoReg=1, RegDst=0. sw (101011) → MEM has MemRead=1, RegWrite never 1; 4 cycles.
- beq with ZERO=1 → EXEC NPCop=1, PCWrite=1. beq with ZERO=0 → NPCop=0. Both 3 cycles, RegWrite=0.
- jal (000011) → DECODE→WB: RegDst=2, MemtoReg=2, NPCop=2, RegWrite=1. jr (R/001000) → EXEC NPCop=3, no RegWrite.
- Unknown op 111111 → retire in DECODE (2 cycles), NPCop=0. Reset asserted during lw MEM → next state FETCH, no WB occurs.
- With CTRL_INSTRET_EN: 10 mixed instructions → instret=10. Without it: instret stays 0.
